dcache_param: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the external data RAM.
- Successor to the single-word cache: configurable set count and multi-word lines, burst line fill under the ram_data_ready handshake, byte-lane write merge, and an invalidate-all input.
- Raises stallreq to ctrl while a fill or RAM write is outstanding.

---
 rtl/dcache_param_pkg.sv | 27 ++
 rtl/dcache_array.sv | 71 +++++++
 rtl/dcache_param.sv | 172 +++++++++++++++++
 tb/tb_dcache_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_param_pkg.sv
// Shared types and width helpers for the parametrised direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } cache_state_t;

    localparam logic CACHE_HIT  = 1'b1;
    localparam logic CACHE_MISS = 1'b0;

    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int words);
        return addr_w - 2 - $clog2(words) - $clog2(sets);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid flops, tag store and data store of the cache, combinational read, one byte-enabled write.
// Latency: read 0 cycles, write visible after the next rising edge.
// Backpressure: none; the controller sequences all writes.
module dcache_array
    import dcache_param_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic              clr_valid
);
    localparam int OFF_W = offset_width(WORDS);
    localparam int IDX_W = index_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS, WORDS);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*WORDS];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [OFF_W-1:0] rd_off, wr_off;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             unused_lsbs;

    assign rd_off = rd_addr[2 +: OFF_W];
    assign rd_idx = rd_addr[2+OFF_W +: IDX_W];
    assign rd_tag = rd_addr[ADDR_W-1 -: TAG_W];
    assign wr_off = wr_addr[2 +: OFF_W];
    assign wr_idx = wr_addr[2+OFF_W +: IDX_W];
    assign wr_tag = wr_addr[ADDR_W-1 -: TAG_W];
    assign unused_lsbs = ^{rd_addr[1:0], wr_addr[1:0]};

    assign rd_hit  = (valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag)) ? CACHE_HIT : CACHE_MISS;
    assign rd_data = data_mem[{rd_idx, rd_off}];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_valid) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data stores are plain RAM: contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[{wr_idx, wr_off}][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_param.sv
// Direct-mapped write-through no-write-allocate data cache with burst line fill.
// Latency: load hit 0 cycles; load miss WORDS RAM beats + 2 cycles; store 1 cycle + RAM write.
// Backpressure: stallreq held while a fill or RAM write is outstanding; RAM paces via ram_data_ready.
module dcache_param
    import dcache_param_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              stallreq,
    input  logic              flush_i,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_i,
    input  logic              ram_data_ready
);
    localparam int OFF_W = offset_width(WORDS);

    cache_state_t      state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wsel_q, wsel_d;
    logic              flush_pend_q, flush_pend_d;

    logic [ADDR_W-1:0] rd_addr, wr_addr, fill_addr;
    logic              rd_hit, wr_en, tag_we, clr_valid;
    logic [31:0]       rd_data, wr_data;
    logic [3:0]        wr_be;

    // addr_q holds the line base during a fill, so the beat address is a plain concatenation.
    assign fill_addr = {addr_q[ADDR_W-1:2+OFF_W], cnt_q, 2'b00};

    dcache_array #(
        .SETS   (SETS),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .clr_valid (clr_valid)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wsel_d       = wsel_q;
        flush_pend_d = flush_pend_q;
        mem_data_o   = '0;
        stallreq     = 1'b0;
        ram_ce_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_sel_o    = '0;
        ram_data_o   = '0;
        rd_addr      = mem_addr_i;
        wr_en        = 1'b0;
        wr_addr      = fill_addr;
        wr_be        = '0;
        wr_data      = ram_data_i;
        tag_we       = 1'b0;
        clr_valid    = 1'b0;
        if (rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    // A flush beats any access in the same cycle; the access retries next cycle.
                    if (flush_i || flush_pend_q) begin
                        clr_valid    = 1'b1;
                        flush_pend_d = 1'b0;
                        stallreq     = mem_ce_i;
                    end else if (mem_ce_i && mem_we_i) begin
                        stallreq = 1'b1;
                        addr_d   = {mem_addr_i[ADDR_W-1:2], 2'b00};
                        wdata_d  = mem_data_i;
                        wsel_d   = mem_sel_i;
                        state_d  = ST_WRITE;
                    end else if (mem_ce_i) begin
                        if (rd_hit == CACHE_HIT) begin
                            mem_data_o = rd_data;
                        end else begin
                            stallreq = 1'b1;
                            cnt_d    = '0;
                            addr_d   = {mem_addr_i[ADDR_W-1:2+OFF_W], {(OFF_W+2){1'b0}}};
                            state_d  = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    ram_ce_o   = 1'b1;
                    ram_sel_o  = 4'hF;
                    ram_addr_o = fill_addr;
                    stallreq   = 1'b1;
                    if (flush_i) begin
                        flush_pend_d = 1'b1;
                    end
                    if (ram_data_ready) begin
                        wr_en = 1'b1;
                        wr_be = 4'hF;
                        if (cnt_q == OFF_W'(WORDS-1)) begin
                            tag_we  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    rd_addr    = addr_q;
                    ram_ce_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_addr_o = addr_q;
                    ram_sel_o  = wsel_q;
                    ram_data_o = wdata_q;
                    stallreq   = !ram_data_ready;
                    if (flush_i) begin
                        flush_pend_d = 1'b1;
                    end
                    if (ram_data_ready) begin
                        wr_en   = rd_hit;
                        wr_addr = addr_q;
                        wr_be   = wsel_q;
                        wr_data = wdata_q;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wsel_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wsel_q       <= wsel_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_dcache_param.sv
// Directed bench for dcache_param: fills, hits, byte-merge stores, conflicts, flush and reset.
// RAM model returns addr+0x1000 with a programmable ready delay.
module tb_dcache_param;

    logic        clk;
    logic        rst;
    logic        mem_ce_i, mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq;
    logic        flush_i;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;
    logic        ram_data_ready;

    int n_chk = 0;
    int n_err = 0;
    int rdy_delay = 0;
    int wait_cnt = 0;

    logic [31:0] beat_addr[$];
    logic [31:0] beat_data[$];
    logic [3:0]  beat_sel[$];
    logic        beat_we[$];
    logic        beat_stall[$];
    logic        seen_ce;

    int          cyc;
    logic [31:0] rdat;

    dcache_param #(.SETS(64), .WORDS(4), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_sel_i      (mem_sel_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .stallreq       (stallreq),
        .flush_i        (flush_i),
        .ram_ce_o       (ram_ce_o),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_sel_o      (ram_sel_o),
        .ram_data_o     (ram_data_o),
        .ram_data_i     (ram_data_i),
        .ram_data_ready (ram_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ram_data_i     = ram_addr_o + 32'h1000;
        ram_data_ready = ram_ce_o && (wait_cnt >= rdy_delay);
    end

    always @(posedge clk) begin
        if (ram_ce_o && !ram_data_ready) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
    end

    always @(negedge clk) begin
        if (ram_ce_o) seen_ce = 1'b1;
        if (ram_ce_o && ram_data_ready) begin
            beat_addr.push_back(ram_addr_o);
            beat_data.push_back(ram_data_o);
            beat_sel.push_back(ram_sel_o);
            beat_we.push_back(ram_we_o);
            beat_stall.push_back(stallreq);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one access and holds it until stallreq is low at a sampling point.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] data, output int cycles, output logic [31:0] rd);
        bit done;
        beat_addr.delete(); beat_data.delete(); beat_sel.delete();
        beat_we.delete(); beat_stall.delete();
        seen_ce    = 1'b0;
        mem_ce_i   = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
        cycles     = 0;
        rd         = '0;
        done       = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (!stallreq) begin
                rd   = mem_data_o;
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (done) begin
            @(posedge clk);
            #1;
        end
        mem_ce_i = 1'b0;
        mem_we_i = 1'b0;
        if (!done) chk("access_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b0; mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_sel_i = 0;
        mem_data_i = 0; flush_i = 0; seen_ce = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_ram_ce", 32'(ram_ce_o), 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("idle_stall", 32'(stallreq), 32'd0);
        chk("idle_ram_we", 32'(ram_we_o), 32'd0);
        @(posedge clk); #1;

        // Cold miss: WORDS beats + 2 cycles from request to data
        access(1'b0, 32'h104, 4'h0, 32'h0, cyc, rdat);
        chk("cold_latency", 32'(cyc), 32'd6);
        chk("cold_data", rdat, 32'h0000_1104);
        chk("cold_beats", 32'(beat_addr.size()), 32'd4);
        if (beat_addr.size() == 4) begin
            chk("cold_addr0", beat_addr[0], 32'h100);
            chk("cold_addr1", beat_addr[1], 32'h104);
            chk("cold_addr2", beat_addr[2], 32'h108);
            chk("cold_addr3", beat_addr[3], 32'h10C);
            chk("cold_we", 32'(beat_we[3]), 32'd0);
            chk("cold_sel", 32'(beat_sel[0]), 32'hF);
        end

        access(1'b0, 32'h10C, 4'h0, 32'h0, cyc, rdat);
        chk("hit_latency", 32'(cyc), 32'd1);
        chk("hit_data", rdat, 32'h0000_110C);
        chk("hit_no_ram", 32'(seen_ce), 32'd0);

        // Store hit, lanes 1:0 merged, RAM ready on the 4th WRITE cycle
        rdy_delay = 3;
        access(1'b1, 32'h104, 4'b0011, 32'hAABB_CCDD, cyc, rdat);
        rdy_delay = 0;
        chk("st_latency", 32'(cyc), 32'd5);
        chk("st_beats", 32'(beat_addr.size()), 32'd1);
        if (beat_addr.size() == 1) begin
            chk("st_addr", beat_addr[0], 32'h104);
            chk("st_we", 32'(beat_we[0]), 32'd1);
            chk("st_sel", 32'(beat_sel[0]), 32'b0011);
            chk("st_data", beat_data[0], 32'hAABB_CCDD);
            chk("st_stall_on_rdy", 32'(beat_stall[0]), 32'd0);
        end
        access(1'b0, 32'h104, 4'h0, 32'h0, cyc, rdat);
        chk("merge_latency", 32'(cyc), 32'd1);
        chk("merge_data", rdat, 32'h0000_CCDD);

        // Store miss does not allocate
        access(1'b1, 32'h2000, 4'hF, 32'h1234_5678, cyc, rdat);
        chk("stm_latency", 32'(cyc), 32'd2);
        chk("stm_addr", (beat_addr.size() > 0) ? beat_addr[0] : 32'hFFFF_FFFF, 32'h2000);
        access(1'b0, 32'h2000, 4'h0, 32'h0, cyc, rdat);
        chk("stm_load_latency", 32'(cyc), 32'd6);
        chk("stm_load_data", rdat, 32'h0000_3000);

        // Conflict on index 16
        access(1'b0, 32'h1100, 4'h0, 32'h0, cyc, rdat);
        chk("conf_latency", 32'(cyc), 32'd6);
        chk("conf_data", rdat, 32'h0000_2100);
        access(1'b0, 32'h104, 4'h0, 32'h0, cyc, rdat);
        chk("evict_latency", 32'(cyc), 32'd6);
        chk("evict_data", rdat, 32'h0000_1104);

        // Flush during FILL: fill completes, flush kills it, access refills
        fork
            access(1'b0, 32'h300, 4'h0, 32'h0, cyc, rdat);
            begin
                repeat (2) @(posedge clk);
                #1 flush_i = 1'b1;
                @(posedge clk);
                #1 flush_i = 1'b0;
            end
        join
        chk("flfill_latency", 32'(cyc), 32'd12);
        chk("flfill_data", rdat, 32'h0000_1300);
        chk("flfill_beats", 32'(beat_addr.size()), 32'd8);

        // Flush in IDLE with a load on a valid line
        flush_i = 1'b1;
        fork
            access(1'b0, 32'h300, 4'h0, 32'h0, cyc, rdat);
            begin
                @(posedge clk);
                #1 flush_i = 1'b0;
            end
        join
        chk("flidle_latency", 32'(cyc), 32'd7);
        chk("flidle_data", rdat, 32'h0000_1300);

        // Reset after two fill beats
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h400;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_ce_i = 1'b0;
        @(negedge clk);
        chk("rstfill_lo_stall", 32'(stallreq), 32'd0);
        chk("rstfill_lo_ce", 32'(ram_ce_o), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rstfill_ce", 32'(ram_ce_o), 32'd0);
        chk("rstfill_addr", ram_addr_o, 32'd0);
        chk("rstfill_stall", 32'(stallreq), 32'd0);
        chk("rstfill_data", mem_data_o, 32'd0);
        @(posedge clk); #1;
        access(1'b0, 32'h400, 4'h0, 32'h0, cyc, rdat);
        chk("rstfill_refill_latency", 32'(cyc), 32'd6);
        chk("rstfill_refill_data", rdat, 32'h0000_1400);
        access(1'b0, 32'h104, 4'h0, 32'h0, cyc, rdat);
        chk("rst_cleared_latency", 32'(cyc), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
